load_store_unit: RTL and testbench

Memory-access stage of the single-cycle RISC-V core. It takes load/store requests from the execute datapath and runs them over a req/ack data-memory bus. While an access is outstanding it stalls the core. It returns byte/halfword/word load data, sign- or zero-extended, on `load_data`, which drives the memory input of the write-back source multiplexer.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: runs loads/stores over a req/ack bus, stalls the core while busy.
// Optional macro LSU_MISALIGN_TRAP_EN flags misaligned halfword/word accesses instead of issuing them.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]            bus_be_q, bus_be_d, be_n;
  logic [31:0]           bus_wdata_q, bus_wdata_d, wdata_n, load_data_q, load_data_d, ext;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  req, is_byte, is_half;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;

  assign req     = mem_read | mem_write;
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (state_q == IDLE) && req &&
                    ((is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign stall = (state_q == BUSY) || ((state_q == IDLE) && req && !misalign);

  // Store lane steering; loads always read the full word.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = store_data;
    if (mem_write) begin
      if (is_byte) begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{store_data[7:0]}};
      end else if (is_half) begin
        be_n    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{store_data[15:0]}};
      end
    end
  end

  // Load extraction uses the address bits captured at issue.
  always_comb begin
    rbyte = bus_rdata[8*addr_lo_q +: 8];
    rhalf = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext = {24'b0, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext = {16'b0, rhalf};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;
    bus_err_d   = bus_err_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    case (state_q)
      IDLE: if (req && !misalign) begin
        state_d     = BUSY;
        cnt_d       = 8'd0;
        bus_req_d   = 1'b1;
        bus_we_d    = mem_write;
        bus_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
        bus_be_d    = be_n;
        bus_wdata_d = wdata_n;
        funct3_d    = funct3;
        addr_lo_d   = addr[1:0];
      end
      BUSY: begin
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b0;
          if (!bus_we_q) load_data_d = ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          load_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0;
      bus_wdata_q <= 32'd0;
      load_data_q <= 32'd0;
      bus_err_q   <= 1'b0;
      funct3_q    <= 3'b0;
      addr_lo_q   <= 2'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit: lanes, extension, ack latency, timeout, reset abort.
module tb_load_store_unit;
  logic        clk = 0, reset_n = 0;
  logic        mem_read = 0, mem_write = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, store_data = 0;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 0;
  logic [31:0] bus_rdata = 0;

  int tests = 0, fails = 0;
  logic [31:0] prev_ld = 0;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
    .load_data(load_data), .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rd;
    int          dly;
    logic [3:0]  be;
    logic [31:0] baddr, wd, ld;
    logic        mis;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    @(negedge clk);
    mem_read = !t.we; mem_write = t.we; funct3 = t.f3; addr = t.addr; store_data = t.sd;
    #1;
    if (t.mis) begin
      chk("mis_flag", 32'(misalign), 1);
      chk("mis_stall", 32'(stall), 0);
      @(negedge clk);
      chk("mis_noreq", 32'(bus_req), 0);
      chk("mis_ld_hold", load_data, prev_ld);
      mem_read = 0; mem_write = 0;
      return;
    end
    chk("idle_stall", 32'(stall), 1);
    chk("no_mis", 32'(misalign), 0);
    @(negedge clk);
    chk("req", 32'(bus_req), 1);
    chk("addr", bus_addr, t.baddr);
    chk("be", 32'(bus_be), 32'(t.be));
    chk("we", 32'(bus_we), 32'(t.we));
    if (t.we) chk("wdata", bus_wdata, t.wd);
    for (int i = 0; i < t.dly; i++) begin
      chk("busy_stall", 32'(stall), 1);
      @(negedge clk);
    end
    chk("busy_addr_stable", bus_addr, t.baddr);
    bus_ack = 1; bus_rdata = t.rd;
    @(negedge clk);
    bus_ack = 0; bus_rdata = 32'h0;
    chk("done_stall", 32'(stall), 0);
    chk("done_req", 32'(bus_req), 0);
    chk("done_err", 32'(bus_err), 0);
    if (!t.we) prev_ld = t.ld;
    chk("load_data", load_data, prev_ld);
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    chk("idle_after", 32'(stall), 0);
  endtask

  initial begin
    int cnt;
    //            we f3      addr        sd            rd            dly be       baddr       wd            ld            mis
    tbl[0]  = '{0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h104, 32'h0,        32'hDEADBEEF, 0};
    tbl[1]  = '{1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        0, 4'b1000, 32'h200, 32'hA5A5A5A5, 32'h0,        0};
    tbl[2]  = '{0, 3'b000, 32'h102, 32'h0,        32'h00800000, 1, 4'b1111, 32'h100, 32'h0,        32'hFFFFFF80, 0};
    tbl[3]  = '{0, 3'b100, 32'h102, 32'h0,        32'h00800000, 2, 4'b1111, 32'h100, 32'h0,        32'h00000080, 0};
    tbl[4]  = '{0, 3'b001, 32'h102, 32'h0,        32'h80000000, 0, 4'b1111, 32'h100, 32'h0,        32'hFFFF8000, 0};
    tbl[5]  = '{0, 3'b101, 32'h100, 32'h0,        32'h1234ABCD, 3, 4'b1111, 32'h100, 32'h0,        32'h0000ABCD, 0};
    tbl[6]  = '{1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,        0, 4'b1100, 32'h100, 32'hBEEFBEEF, 32'h0,        0};
    tbl[7]  = '{1, 3'b010, 32'h010, 32'h12345678, 32'h0,        1, 4'b1111, 32'h010, 32'h12345678, 32'h0,        0};
    tbl[8]  = '{0, 3'b011, 32'h020, 32'h0,        32'hCAFEF00D, 15, 4'b1111, 32'h020, 32'h0,       32'hCAFEF00D, 0};
    tbl[9]  = '{1, 3'b000, 32'h001, 32'h0000003C, 32'h0,        0, 4'b0010, 32'h000, 32'h3C3C3C3C, 32'h0,        0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[10] = '{1, 3'b010, 32'h101, 32'h55667788, 32'h0,        0, 4'b1111, 32'h100, 32'h55667788, 32'h0,        1};
    tbl[11] = '{0, 3'b001, 32'h103, 32'h0,        32'hFFEE0000, 0, 4'b1111, 32'h100, 32'h0,        32'hFFFFFFEE, 1};
`else
    tbl[10] = '{1, 3'b010, 32'h101, 32'h55667788, 32'h0,        0, 4'b1111, 32'h100, 32'h55667788, 32'h0,        0};
    tbl[11] = '{0, 3'b001, 32'h103, 32'h0,        32'hFFEE0000, 0, 4'b1111, 32'h100, 32'h0,        32'hFFFFFFEE, 0};
`endif

    #12;
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_be", 32'(bus_be), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_stall", 32'(stall), 0);
    @(negedge clk); reset_n = 1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Timeout: no ack, request must stay up for exactly TIMEOUT_CYCLES cycles.
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; addr = 32'h40;
    #1 chk("to_idle_stall", 32'(stall), 1);
    @(negedge clk);
    cnt = 0;
    while (bus_req && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(cnt), 16);
    chk("to_err", 32'(bus_err), 1);
    chk("to_ld", load_data, 0);
    chk("to_stall", 32'(stall), 0);
    prev_ld = 0;
    mem_read = 0;
    @(negedge clk);
    chk("to_err_hold", 32'(bus_err), 1);

    run_vec(tbl[0]);

    // Reset during BUSY aborts; a stray ack afterwards is ignored.
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    chk("ra_req", 32'(bus_req), 1);
    reset_n = 0; mem_read = 0;
    #1;
    chk("ra_req_clr", 32'(bus_req), 0);
    chk("ra_stall", 32'(stall), 0);
    chk("ra_ld", load_data, 0);
    @(negedge clk);
    reset_n = 1; bus_ack = 1; bus_rdata = 32'h11111111;
    @(negedge clk);
    bus_ack = 0;
    chk("ra_ack_ign_ld", load_data, 0);
    chk("ra_ack_ign_req", 32'(bus_req), 0);
    chk("ra_ack_ign_stall", 32'(stall), 0);
    prev_ld = 0;
    run_vec(tbl[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
